ts_gen_ctrl: RTL
================

# ts_gen_ctrl

Sequencing controller between the LTSSM and the TS generator. It accepts state/sub-state requests from the LTSSM and drives the generator's `ts_info`/`ts_update` handshake. It tracks the generator's running status, counts transmitted TS beats, and qualifies the generator's sent-enough flag. It also flags a generator that never acknowledges an update.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 64: cycles allowed in ISSUE without an ack before error.
- `CNT_W`, default 16: width of the TS beat counter.

Ports:
- `clk` in 1: system clock (1 GHz).
- `rst` in 1: reset, synchronous, active-high. Clock is `clk`.
- `req_valid` in 1: LTSSM requests a new TS configuration.
- `req_info` in 8: `{state[7:4], sub_state[3:0]}` per `define.v` encodings.
- `req_stop` in 1: LTSSM requests TS transmission halt.
- `req_ready` out 1: controller can accept a request this cycle.
- `gen_ts_info` out 8: registered copy of the accepted `req_info`.
- `gen_ts_update` out 1: update strobe to the generator.
- `gen_ts_update_ack` in 1: generator acknowledge.
- `gen_ts_stop` out 1: stop level to the generator.
- `gen_sent_enough` in 1: generator's target-reached flag.
- `gen_ts_valid` in 1: generator emitted a TS beat this cycle.
- `ts_sent_enough` out 1: qualified sent-enough to the LTSSM.
- `ts_sent_cnt` out `CNT_W`: TS beats since the last load; saturating.
- `ack_err` out 1: one-cycle pulse when an ack timeout fires.

## Operation
- States: IDLE, ISSUE, COOL, RUN.
- IDLE: `req_ready`=1.
  - `req_valid` latches `req_info` into `gen_ts_info`, sets `gen_ts_update`=1, clears `ts_sent_cnt`, clears the timeout counter, clears `gen_ts_stop`, and moves to ISSUE.
- ISSUE: `gen_ts_update` is held high until `gen_ts_update_ack`=1 is sampled.
  - On ack, the next cycle has `gen_ts_update`=0 and the state moves to COOL.
  - The timeout counter increments every ISSUE cycle. On reaching `ACK_TIMEOUT`: `ack_err` pulses, `gen_ts_update` drops, and the state returns to IDLE.
- COOL: wait until `gen_ts_update_ack`=0 is sampled, then move to RUN.
  - This covers the generator's two-cycle ack when it is retargeted while already running.
- RUN: `req_ready`=1.
  - `ts_sent_cnt` increments on each `gen_ts_valid` cycle and saturates at all-ones.
  - `req_valid` behaves as in IDLE and moves to ISSUE. An identical `req_info` is still reissued and restarts counting.
  - `req_stop` sets `gen_ts_stop`=1 and moves to IDLE. `ts_sent_cnt` is frozen.
- `req_stop` and `req_valid` asserted in the same cycle: stop wins and the request is dropped.
- `req_stop` in IDLE: `gen_ts_stop` is set; no other effect.
- `req_stop` in ISSUE or COOL: ignored; `req_ready`=0, so the LTSSM must hold it.
- `ts_sent_enough` = `gen_sent_enough` AND state==RUN. It is forced to 0 in ISSUE and COOL so that a stale flag from the previous configuration is masked.
- `req_ready`=0 in ISSUE and COOL. `req_valid` in those states is ignored and is not queued.

## Timing
- All outputs are registered.
- Reset values: every output is 0, `gen_ts_info`=8'h00, state=IDLE.
- Request accepted in cycle t → `gen_ts_update`=1 and `gen_ts_info` valid at t+1.
- Generator idle: ack at t+2 → update low at t+3. Ack low at t+3 → RUN at t+4.
- Generator running: ack at t+2 and t+3 → COOL holds until ack samples low (t+4) → RUN at t+5.
- `ts_sent_cnt` reflects `gen_ts_valid` one cycle later.
- `ack_err` is a single-cycle pulse, registered in the cycle after the timeout count is reached.
- Reset mid-handshake: `gen_ts_update` is 0 in the cycle after `rst` is sampled high. The generator is reset by the same `rst`.

## Structure
- State encodings for IDLE, ISSUE, COOL and RUN, and the `ACK_TIMEOUT` default, go as macros in `define.v`, alongside the existing POLL/CFG and sub-state encodings.
- A single-file module is preferred.
- An optional sub-module `sat_cnt` (parameterised width; clear, enable, saturate) may be used for both `ts_sent_cnt` and the timeout counter.

## Test plan
- Reset, then a POLL/POLL_ACTIVE request with the generator idle → `gen_ts_update` high exactly 2 cycles, `gen_ts_info` matches the request, RUN at t+4, `ts_sent_cnt` counts `gen_ts_valid` beats.
- In RUN, a CFG/CFG_COMPLETE request → 2-cycle ack honoured. `ts_sent_enough` is 0 from acceptance until RUN, then follows `gen_sent_enough`. `ts_sent_cnt` restarts from 0.
- Ack never returned → `ack_err` pulses after 64 ISSUE cycles, state returns to IDLE, `gen_ts_update`=0.
- `req_stop` and `req_valid` in the same RUN cycle → `gen_ts_stop`=1, no update issued, `req_ready` remains 1.
- Force 65535 valid beats → `ts_sent_cnt` holds at 16'hFFFF.
- Assert `rst` during ISSUE → all outputs 0 next cycle. A new request after reset completes normally.

Source files
------------

// File: rtl/ts_gen_ctrl_pkg.sv
// Shared encodings for the LTSSM-to-TS-generator sequencing controller.
// Holds controller state codes, the default ack timeout and LTSSM state/sub-state codes.
package ts_gen_ctrl_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_COOL  = 2'd2;
    localparam logic [1:0] ST_RUN   = 2'd3;

    localparam int ACK_TIMEOUT_DEF = 64;

    localparam logic [3:0] LTSSM_POLL = 4'h2;
    localparam logic [3:0] LTSSM_CFG  = 4'h3;

    localparam logic [3:0] POLL_ACTIVE     = 4'h0;
    localparam logic [3:0] POLL_CONFIG     = 4'h2;
    localparam logic [3:0] CFG_LINKWD_ST   = 4'h0;
    localparam logic [3:0] CFG_COMPLETE    = 4'h4;

    typedef struct packed {
        logic [3:0] state;
        logic [3:0] sub_state;
    } ts_info_t;

    function automatic logic [7:0] make_ts_info(input logic [3:0] state, input logic [3:0] sub_state);
        ts_info_t info;
        info.state     = state;
        info.sub_state = sub_state;
        return info;
    endfunction

endpackage

// File: rtl/ts_gen_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Used for both the TS beat count and the ack timeout count.
module ts_gen_ctrl_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ts_gen_ctrl.sv
// Sequences LTSSM TS configuration requests into the TS generator update handshake,
// counts transmitted TS beats and flags a generator that never acknowledges.
//
// state | meaning
// IDLE  | no active configuration; accepts request or stop
// ISSUE | update strobe held high, waiting for ack or timeout
// COOL  | ack seen, waiting for ack to drop (running generator acks twice)
// RUN   | generator transmitting; beats counted, sent-enough passed through
module ts_gen_ctrl
    import ts_gen_ctrl_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [7:0]       req_info,
    input  logic             req_stop,
    output logic             req_ready,
    output logic [7:0]       gen_ts_info,
    output logic             gen_ts_update,
    input  logic             gen_ts_update_ack,
    output logic             gen_ts_stop,
    input  logic             gen_sent_enough,
    input  logic             gen_ts_valid,
    output logic             ts_sent_enough,
    output logic [CNT_W-1:0] ts_sent_cnt,
    output logic             ack_err
);

    localparam int TO_W = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    logic [1:0]      state, state_n;
    logic [7:0]      info_n;
    logic            update_n, stop_n, err_n;
    logic            accept, beat_en;
    logic [TO_W-1:0] to_cnt;

    always_comb begin
        state_n  = state;
        info_n   = gen_ts_info;
        update_n = gen_ts_update;
        stop_n   = gen_ts_stop;
        err_n    = 1'b0;
        accept   = 1'b0;
        beat_en  = 1'b0;
        case (state)
            ST_IDLE, ST_RUN: begin
                // req_ready is low only in the first cycle out of reset
                if (req_ready) begin
                    if (req_stop) begin
                        stop_n  = 1'b1;
                        state_n = ST_IDLE;
                    end else if (req_valid) begin
                        accept   = 1'b1;
                        info_n   = req_info;
                        update_n = 1'b1;
                        stop_n   = 1'b0;
                        state_n  = ST_ISSUE;
                    end else if (state == ST_RUN) begin
                        beat_en = gen_ts_valid;
                    end
                end
            end
            ST_ISSUE: begin
                if (gen_ts_update_ack) begin
                    update_n = 1'b0;
                    state_n  = ST_COOL;
                end else if (to_cnt == TO_LAST) begin
                    update_n = 1'b0;
                    err_n    = 1'b1;
                    state_n  = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (!gen_ts_update_ack) begin
                    state_n = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b0;
            gen_ts_info    <= 8'h00;
            gen_ts_update  <= 1'b0;
            gen_ts_stop    <= 1'b0;
            ts_sent_enough <= 1'b0;
            ack_err        <= 1'b0;
        end else begin
            state          <= state_n;
            req_ready      <= (state_n == ST_IDLE) || (state_n == ST_RUN);
            gen_ts_info    <= info_n;
            gen_ts_update  <= update_n;
            gen_ts_stop    <= stop_n;
            ts_sent_enough <= gen_sent_enough && (state_n == ST_RUN);
            ack_err        <= err_n;
        end
    end

    ts_gen_ctrl_sat_cnt #(.W(CNT_W)) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (beat_en),
        .cnt (ts_sent_cnt)
    );

    ts_gen_ctrl_sat_cnt #(.W(TO_W)) u_to_cnt (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .en  (state == ST_ISSUE),
        .cnt (to_cnt)
    );

endmodule
